// File: rtl/mpm_pkg.sv
// mpm_pkg: move codes, obstacle codes, FSM encoding and colours shared by multi_player_mover.
package mpm_pkg;
    localparam logic [2:0] MV_NONE  = 3'd0;
    localparam logic [2:0] MV_UP    = 3'd1;
    localparam logic [2:0] MV_DOWN  = 3'd2;
    localparam logic [2:0] MV_LEFT  = 3'd3;
    localparam logic [2:0] MV_RIGHT = 3'd4;
    localparam logic [2:0] OB_EMPTY = 3'd0;
    localparam logic [2:0] OB_WALL  = 3'd1;
    localparam logic [2:0] OB_LAVA  = 3'd2;
    localparam logic [2:0] OB_ICE   = 3'd3;
    localparam logic [2:0] COLOR_ERASE = 3'b000;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_ERASE  = 3'd2,
        S_LOOKUP = 3'd3,
        S_WAIT   = 3'd4,
        S_DECIDE = 3'd5,
        S_DRAW   = 3'd6
    } state_t;
    function automatic logic is_move(input logic [2:0] code);
        return code >= MV_UP && code <= MV_RIGHT;
    endfunction
endpackage

// File: rtl/mpm_tick_timer.sv
// mpm_tick_timer: game tick generator; a tick landing while a round is busy is held in a one-deep pending flag.
module mpm_tick_timer
    import mpm_pkg::*;
#(
    parameter int TICK_CYCLES = 833_333
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic busy_i,
    input  logic take_i,
    output logic tick_o,
    output logic pending_o
);
    localparam int W = $clog2(TICK_CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    logic         pend_q, pend_d;
    assign tick_o    = cnt_q == W'(TICK_CYCLES - 1);
    assign pending_o = pend_q;
    always_comb begin
        cnt_d  = tick_o ? '0 : cnt_q + W'(1);
        pend_d = take_i ? 1'b0 : (tick_o && busy_i) ? 1'b1 : pend_q;
    end
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/multi_player_mover.sv
// multi_player_mover: per game tick, services each live player round-robin (erase, ROM lookup, rules, redraw).
// Define MPM_WRAP_EN to make edge steps wrap around the playfield; otherwise an edge step behaves like a wall.
module multi_player_mover
    import mpm_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int X_MAX        = 159,
    parameter int Y_MAX        = 119,
    parameter int TICK_CYCLES  = 833_333,
    parameter int FREEZE_TICKS = 30,
    parameter int X_START      = 20
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_PLAYERS-1:0]     move_valid_i,
    input  logic [3*NUM_PLAYERS-1:0]   move_dir_i,
    input  logic [2:0]                 obs_mem_i,
    output logic [7:0]                 obs_x_o,
    output logic [6:0]                 obs_y_o,
    output logic [7:0]                 x_o,
    output logic [6:0]                 y_o,
    output logic [2:0]                 color_draw_o,
    output logic                       plot_o,
    output logic [NUM_PLAYERS-1:0]     alive_o,
    output logic [NUM_PLAYERS-1:0]     frozen_o,
    output logic                       busy_o,
    output logic [2:0]                 state_o
);
    localparam int N  = NUM_PLAYERS;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = (FREEZE_TICKS > 0) ? $clog2(FREEZE_TICKS + 1) : 1;
    localparam logic [7:0] XM = 8'(X_MAX);
    localparam logic [6:0] YM = 7'(Y_MAX);
`ifdef MPM_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      px_q[N], px_d[N];
    logic [6:0]      py_q[N], py_d[N];
    logic [2:0]      pend_q[N], pend_d[N];
    logic [FW-1:0]   fcnt_q[N], fcnt_d[N];
    logic [N-1:0]    alive_q, alive_d, frozen_q, frozen_d;
    logic [7:0]      tx_q, tx_d, tgt_x, cx;
    logic [6:0]      ty_q, ty_d, tgt_y, cy;
    logic            blk_q, blk_d, tgt_blk, at_edge, coll;
    logic [2:0]      mv, code;
    logic            tick, tick_pend, take, last, skip, draw_en, addr_en;

    mpm_tick_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .busy_i   (busy_o),
        .take_i   (take),
        .tick_o   (tick),
        .pending_o(tick_pend)
    );

    assign busy_o   = state_q != S_IDLE;
    assign take     = state_q == S_IDLE && (tick || tick_pend);
    assign last     = ptr_q == PW'(N - 1);
    assign skip     = !alive_q[ptr_q] || frozen_q[ptr_q] || pend_q[ptr_q] == MV_NONE;
    assign code     = blk_q ? OB_WALL : obs_mem_i;
    assign draw_en  = state_q == S_DRAW && alive_q[ptr_q];
    assign addr_en  = state_q == S_LOOKUP || state_q == S_WAIT || state_q == S_DECIDE;

    // Target cell is resolved with compares before any add/sub so edges never rely on overflow.
    always_comb begin
        cx = px_q[ptr_q];
        cy = py_q[ptr_q];
        mv = pend_q[ptr_q];
        at_edge = (mv == MV_UP && cy == 7'd0) || (mv == MV_DOWN && cy == YM) ||
                  (mv == MV_LEFT && cx == 8'd0) || (mv == MV_RIGHT && cx == XM);
        tgt_x = mv == MV_LEFT  ? (cx == 8'd0 ? (WRAP ? XM : cx) : cx - 8'd1) :
                mv == MV_RIGHT ? (cx == XM ? (WRAP ? 8'd0 : cx) : cx + 8'd1) : cx;
        tgt_y = mv == MV_UP    ? (cy == 7'd0 ? (WRAP ? YM : cy) : cy - 7'd1) :
                mv == MV_DOWN  ? (cy == YM ? (WRAP ? 7'd0 : cy) : cy + 7'd1) : cy;
        coll = 1'b0;
        for (int j = 0; j < N; j++)
            if (PW'(j) != ptr_q && alive_q[j] && px_q[j] == tgt_x && py_q[j] == tgt_y) coll = 1'b1;
        tgt_blk = coll || (at_edge && !WRAP);
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        px_d     = px_q;
        py_d     = py_q;
        pend_d   = pend_q;
        fcnt_d   = fcnt_q;
        alive_d  = alive_q;
        frozen_d = frozen_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        blk_d    = blk_q;
        case (state_q)
            S_IDLE: begin
                ptr_d   = '0;
                state_d = take ? S_SELECT : S_IDLE;
            end
            S_SELECT: begin
                pend_d[ptr_q] = MV_NONE;
                if (skip) begin
                    state_d = last ? S_IDLE : S_SELECT;
                    ptr_d   = last ? '0 : ptr_q + PW'(1);
                    if (frozen_q[ptr_q]) begin
                        frozen_d[ptr_q] = fcnt_q[ptr_q] != '0;
                        fcnt_d[ptr_q]   = fcnt_q[ptr_q] - FW'(fcnt_q[ptr_q] != '0);
                    end
                end else begin
                    state_d = S_ERASE;
                    tx_d    = tgt_x;
                    ty_d    = tgt_y;
                    blk_d   = tgt_blk;
                end
            end
            S_ERASE:  state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_WAIT;
            S_WAIT:   state_d = S_DECIDE;
            S_DECIDE: begin
                state_d = S_DRAW;
                if (code != OB_WALL) begin
                    px_d[ptr_q] = tx_q;
                    py_d[ptr_q] = ty_q;
                end
                if (code == OB_LAVA) alive_d[ptr_q] = 1'b0;
                if (code == OB_ICE) begin
                    frozen_d[ptr_q] = 1'b1;
                    fcnt_d[ptr_q]   = FW'(FREEZE_TICKS);
                end
            end
            S_DRAW: begin
                state_d = last ? S_IDLE : S_SELECT;
                ptr_d   = last ? '0 : ptr_q + PW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // A fresh request beats the service clear, so it waits for the next tick.
        for (int k = 0; k < N; k++)
            if (move_valid_i[k] && is_move(move_dir_i[3*k +: 3])) pend_d[k] = move_dir_i[3*k +: 3];
    end

    assign plot_o       = state_q == S_ERASE || draw_en;
    assign x_o          = plot_o ? px_q[ptr_q] : '0;
    assign y_o          = plot_o ? py_q[ptr_q] : '0;
    assign color_draw_o = draw_en ? 3'(ptr_q) + 3'd1 : COLOR_ERASE;
    assign obs_x_o      = addr_en ? tx_q : '0;
    assign obs_y_o      = addr_en ? ty_q : '0;
    assign alive_o      = alive_q;
    assign frozen_o     = frozen_q;
    assign state_o      = state_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            alive_q  <= '1;
            frozen_q <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            blk_q    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                px_q[i]   <= 8'(X_START + 40 * i);
                py_q[i]   <= 7'(Y_MAX / 2);
                pend_q[i] <= MV_NONE;
                fcnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            alive_q  <= alive_d;
            frozen_q <= frozen_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            blk_q    <= blk_d;
            px_q     <= px_d;
            py_q     <= py_d;
            pend_q   <= pend_d;
            fcnt_q   <= fcnt_d;
        end
    end
endmodule
